// File: rtl/regfile_pkg.sv
// Shared types for the register-file port sequencer.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        CAP2 = 3'd3,
        HOLD = 3'd4
    } rf_seq_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_port_sequencer.sv
// Serialises rs1/rs2 operand reads and writebacks onto a single-port RF SRAM; REGFILE_BYPASS_EN forwards HOLD writes.
// Latency: operands valid 3 edges after read accept; writes land on their accept edge.
// Backpressure: a write beats a read in IDLE; operands are held until op_ready.
module regfile_port_sequencer
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    rf_seq_state_t         state;
    rf_seq_state_t         state_nxt;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic                  rd_fire;
    logic                  wb_fire;

    // Ready outputs are gated by rst so nothing handshakes in the reset cycle.
    assign rd_req_ready = !rst && (state == IDLE) && !wb_valid;
    assign wb_ready     = !rst && ((state == IDLE) || (state == HOLD));
    assign rd_fire      = rd_req_valid && rd_req_ready;
    assign wb_fire      = wb_valid && wb_ready;
    assign sram_we      = wb_fire && (wb_addr != ZERO_IDX);
    assign op_valid     = (state == HOLD);

    always_comb begin
        sram_addr = ZERO_IDX;
        sram_din  = '0;
        if (sram_we) begin
            sram_addr = wb_addr;
            sram_din  = wb_data;
        end else if (state == RD1) begin
            sram_addr = rs1_q;
        end else if (state == RD2) begin
            sram_addr = rs2_q;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rd_fire) state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = CAP2;
            CAP2:    state_nxt = HOLD;
            HOLD:    if (op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rs1_q    <= ZERO_IDX;
            rs2_q    <= ZERO_IDX;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            state <= state_nxt;
            if (rd_fire) begin
                rs1_q <= rs1_addr;
                rs2_q <= rs2_addr;
            end
            // x0 is still read from the SRAM to keep latency fixed; its value is discarded.
            if (state == RD2)
                rs1_data <= (rs1_q == ZERO_IDX) ? '0 : sram_dout;
            if (state == CAP2)
                rs2_data <= (rs2_q == ZERO_IDX) ? '0 : sram_dout;
`ifdef REGFILE_BYPASS_EN
            if ((state == HOLD) && sram_we) begin
                if (rs1_q == wb_addr) rs1_data <= wb_data;
                if (rs2_q == wb_addr) rs2_data <= wb_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a behavioural SRAM and a transaction-level register model.
module tb_regfile_port_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        sram_we;
    logic [4:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_port_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .op_valid(op_valid), .op_ready(op_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Single-port SRAM: registered read, dout held on write cycles.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        else         sram_dout      <= mem[sram_addr];
    end

    // Reference model: architectural registers plus a count of cycles since read accept.
    logic [31:0] regs [32];
    int          busy = 0;
    logic [4:0]  la1 = '0, la2 = '0;
    logic [31:0] m_r1 = '0, m_r2 = '0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 32'hC0DE_0000 | i;
            regs[i] = 32'hC0DE_0000 | i;
        end
        mem[0] = 32'hBADB_AD00;
        sram_dout = '0;
    end

    function automatic logic [31:0] arch_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : regs[a];
    endfunction

    always @(posedge clk) begin : model
        bit wf;
        if (rst) begin
            busy = 0;
            m_r1 = '0;
            m_r2 = '0;
        end else begin
            wf = wb_valid && (busy == 0 || busy == 4);
            if (busy == 0) begin
                if (wf) begin
                    if (wb_addr != 0) regs[wb_addr] = wb_data;
                end else if (rd_req_valid) begin
                    la1  = rs1_addr;
                    la2  = rs2_addr;
                    busy = 1;
                end
            end else if (busy < 4) begin
                busy = busy + 1;
                if (busy == 4) begin
                    m_r1 = arch_rd(la1);
                    m_r2 = arch_rd(la2);
                end
            end else begin
                if (wf && wb_addr != 0) begin
                    regs[wb_addr] = wb_data;
`ifdef REGFILE_BYPASS_EN
                    if (la1 == wb_addr) m_r1 = wb_data;
                    if (la2 == wb_addr) m_r2 = wb_data;
`endif
                end
                if (op_ready) busy = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        bit         wf, we_e;
        logic [4:0] a_e;
        wf   = !rst && wb_valid && (busy == 0 || busy == 4);
        we_e = wf && (wb_addr != 0);
        a_e  = we_e ? wb_addr : (busy == 1) ? la1 : (busy == 2) ? la2 : 5'd0;
        check("rd_req_ready", {31'b0, rd_req_ready}, {31'b0, !rst && busy == 0 && !wb_valid});
        check("wb_ready", {31'b0, wb_ready}, {31'b0, !rst && (busy == 0 || busy == 4)});
        check("sram_we", {31'b0, sram_we}, {31'b0, we_e});
        check("sram_addr", {27'b0, sram_addr}, {27'b0, a_e});
        check("sram_din", sram_din, we_e ? wb_data : 32'h0);
        check("op_valid", {31'b0, op_valid}, {31'b0, busy == 4});
        if (busy == 4) begin
            check("rs1_data", rs1_data, m_r1);
            check("rs2_data", rs2_data, m_r2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        int n;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        #1;
        n = 0;
        while (!wb_ready && n < 20) begin
            tick();
            n++;
        end
        check("wb_wait", n, 0);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2, output int lat);
        int n;
        rd_req_valid = 1'b1;
        rs1_addr     = a1;
        rs2_addr     = a2;
        #1;
        n = 0;
        while (!rd_req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        rd_req_valid = 1'b0;
        rs1_addr     = 5'd31;
        rs2_addr     = 5'd30;
        lat = 0;
        while (!op_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_ops();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        logic [31:0] exp_byp;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_op_valid", {31'b0, op_valid}, 32'h0);
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);
        check("reset_rd_ready", {31'b0, rd_req_ready}, 32'h1);

        do_write(5'd5, 32'h0000_00AA);
        do_read(5'd5, 5'd0, lat);
        check("lat_basic", lat, 3);
        check("lit_rs1_aa", rs1_data, 32'h0000_00AA);
        check("lit_rs2_x0", rs2_data, 32'h0);
        release_ops();

        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'hFFFF_FFFF;
        #1;
        check("x0_wb_ready", {31'b0, wb_ready}, 32'h1);
        check("x0_no_we", {31'b0, sram_we}, 32'h0);
        tick();
        wb_valid = 1'b0;
        do_read(5'd0, 5'd0, lat);
        check("lit_x0_rs1", rs1_data, 32'h0);
        check("lit_x0_rs2", rs2_data, 32'h0);
        release_ops();

        wb_valid     = 1'b1;
        wb_addr      = 5'd3;
        wb_data      = 32'h0000_1234;
        rd_req_valid = 1'b1;
        rs1_addr     = 5'd3;
        rs2_addr     = 5'd3;
        #1;
        check("prio_rd_ready", {31'b0, rd_req_ready}, 32'h0);
        check("prio_we", {31'b0, sram_we}, 32'h1);
        tick();
        wb_valid = 1'b0;
        do_read(5'd3, 5'd3, lat);
        check("lat_prio", lat, 3);
        check("lit_rs1_1234", rs1_data, 32'h0000_1234);
        check("lit_rs2_1234", rs2_data, 32'h0000_1234);
        release_ops();

        do_write(5'd7, 32'h0000_5555);
        do_read(5'd7, 5'd7, lat);
        repeat (2) tick();
        do_write(5'd7, 32'h0000_DEAD);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_DEAD;
`else
        exp_byp = 32'h0000_5555;
`endif
        check("hold_op_valid", {31'b0, op_valid}, 32'h1);
        check("byp_rs1", rs1_data, exp_byp);
        check("byp_rs2", rs2_data, exp_byp);
        release_ops();
        do_read(5'd7, 5'd1, lat);
        check("lit_new_x7", rs1_data, 32'h0000_DEAD);
        check("lit_init_x1", rs2_data, 32'hC0DE_0001);
        release_ops();

        do_read(5'd9, 5'd2, lat);
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h0000_0099;
        op_ready = 1'b1;
        tick();
        wb_valid = 1'b0;
        op_ready = 1'b0;
        #1;
        check("hold_both_idle", {31'b0, rd_req_ready}, 32'h1);
        check("hold_both_ov", {31'b0, op_valid}, 32'h0);
        do_read(5'd9, 5'd9, lat);
        check("lit_x9", rs1_data, 32'h0000_0099);
        release_ops();

        op_ready = 1'b1;
        do_read(5'd5, 5'd5, lat);
        check("pulse_hi", {31'b0, op_valid}, 32'h1);
        tick();
        check("pulse_lo", {31'b0, op_valid}, 32'h0);
        op_ready = 1'b0;

        rd_req_valid = 1'b1;
        rs1_addr     = 5'd6;
        rs2_addr     = 5'd6;
        tick();
        rd_req_valid = 1'b0;
        tick();
        rst      = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        wb_data  = 32'hFFFF_0000;
        #1;
        check("rst_no_we", {31'b0, sram_we}, 32'h0);
        check("rst_no_wb_ready", {31'b0, wb_ready}, 32'h0);
        tick();
        rst      = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("rst_op_valid", {31'b0, op_valid}, 32'h0);
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_idle", {31'b0, rd_req_ready}, 32'h1);
        do_read(5'd4, 5'd4, lat);
        check("lat_after_rst", lat, 3);
        check("lit_x4_kept", rs1_data, 32'hC0DE_0004);
        release_ops();

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_port_sequencer.md
# regfile_port_sequencer

Sequences decode-stage operand reads and writeback-stage writes onto the single-port, 32-entry register-file SRAM. The SRAM has registered read data with one-cycle latency, performs either a write or a read per cycle, and holds `dout` on write cycles. This block sits between decode/writeback and that SRAM. It serializes the two source reads of an instruction, enforces x0 = 0, and returns both operands through a valid/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_req_valid  in  1  decode presents an operand-read request
- rd_req_ready  out  1  request accepted on the same edge when valid && ready
- rs1_addr, rs2_addr  in  ADDR_WIDTH each  source register indices
- op_valid  out  1  rs1_data/rs2_data valid
- op_ready  in  1  consumer takes the operands
- rs1_data, rs2_data  out  DATA_WIDTH each  captured operands
- wb_valid  in  1  writeback request
- wb_ready  out  1  write accepted on the same edge
- wb_addr  in  ADDR_WIDTH  destination index
- wb_data  in  DATA_WIDTH  write data
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_din  out  DATA_WIDTH  SRAM write data
- sram_dout  in  DATA_WIDTH  SRAM registered read data

## Operation
- FSM states:
  - IDLE: waits for writeback or read request.
  - RD1: issues the rs1 read.
  - RD2: captures rs1 data and issues the rs2 read.
  - CAP2: captures rs2 data.
  - HOLD: presents operands.
- Transitions:
  - IDLE -> RD1 on a read handshake.
  - RD1 -> RD2 -> CAP2 -> HOLD unconditionally.
  - HOLD -> IDLE when op_ready is high.
- Request latching: rs1_addr and rs2_addr are latched on the read handshake. Input changes after that edge are ignored.
- Write priority:
  - wb_ready = 1 in IDLE and HOLD; 0 in all other states.
  - rd_req_ready = (state == IDLE) && !wb_valid. A write in IDLE always wins over a read request.
- Write path (combinational):
  - sram_we = wb_valid && wb_ready && (wb_addr != 0).
  - On write cycles: sram_addr = wb_addr, sram_din = wb_data.
- Read path:
  - In RD1: sram_addr = rs1 index, sram_we = 0.
  - In RD2: sram_addr = rs2 index, sram_we = 0.
  - In all other non-write cycles: sram_addr = 0, sram_din = 0.
- x0 handling:
  - A write to x0 completes the handshake but asserts no sram_we.
  - A read of x0 still issues the SRAM read, so latency is fixed, but the captured value is forced to 0.
- Same-register sources: if rs1 == rs2, two reads are still issued and both captures are independent.
- Operand stability: rs1_data and rs2_data are stable while op_valid = 1, except as defined under Configuration.

## Timing
- Reset values: state IDLE, op_valid 0, rs1_data 0, rs2_data 0.
- During rst: rd_req_ready = 0, wb_ready = 0, sram_we = 0.
- Reset mid-sequence abandons the request. No SRAM write occurs in the reset cycle.
- Read latency:
  - Read handshake at edge E0.
  - rs1 captured at E2, rs2 captured at E3.
  - op_valid rises after E3.
- Throughput: minimum 5 cycles per operand pair (IDLE, RD1, RD2, CAP2, HOLD). No back-to-back acceptance from HOLD.
- Write latency: the SRAM array updates at the write handshake edge. A read request accepted at any later edge observes the new value.
- Simultaneous events in HOLD:
  - A write and op_ready in the same cycle both complete.
  - The next state is IDLE.
- op_valid is held until op_ready. With op_ready tied high, op_valid is a one-cycle pulse.

## Configuration
- REGFILE_BYPASS_EN defined: in HOLD, an accepted write with wb_addr != 0 updates, on that edge, each captured operand whose latched index equals wb_addr, including both when rs1 == rs2.
- REGFILE_BYPASS_EN undefined: the write goes to the SRAM only and the captured operands remain unchanged (stale). Hazard resolution is then the pipeline's responsibility.

## Structure
- Shared package `regfile_pkg` contains:
  - the FSM state enum `rf_seq_state_t` (IDLE, RD1, RD2, CAP2, HOLD);
  - the constant `REG_ZERO` = 5'd0.
- No sub-module. One FSM plus capture registers in a single module.
- The SRAM is instantiated by the parent and connected through the sram_* ports.

## Test plan
- Reset, then write x5 = 0x0000_00AA, then read rs1 = 5, rs2 = 0 -> op_valid rises 3 edges after accept; rs1_data = 0xAA, rs2_data = 0.
- Write x0 = 0xFFFF_FFFF -> wb handshake completes, sram_we stays 0; a later read of x0 returns 0.
- wb_valid and rd_req_valid asserted together in IDLE (write x3 = 0x1234, read rs1 = 3) -> write first, rd_req_ready = 0 that cycle; the read then returns 0x1234.
- In HOLD with op_ready = 0, write x7 = 0xDEAD while rs1 = rs2 = 7 -> with REGFILE_BYPASS_EN both operands become 0xDEAD; without it both keep the old value.
- Assert rst in RD2 -> next cycle state IDLE, op_valid 0, operands 0, no sram_we during rst.
